muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: sequential shift-add multiply and restoring divide, one-cycle write-back.
// Define MULDIV_FAST_MUL_EN to compute all multiplies combinationally in a single cycle.
module muldiv_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [REG_AW-1:0] rd,
  input  logic              flush,
  output logic              busy,
  output logic              wb_enable,
  output logic [REG_AW-1:0] wb_reg,
  output logic [XLEN-1:0]   wb_data
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned DW = 2 * XLEN;
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic                neg_q, neg_d;
  logic [DW-1:0]       acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [REG_AW-1:0]   wb_reg_q, wb_reg_d;
  logic [XLEN-1:0]     wb_data_q, wb_data_d;

  logic                signed_a, signed_b, neg_a, neg_b, is_div, op_neg;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                special_hit;
  logic [XLEN-1:0]     special_res;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [DW-1:0]       mul_nxt, div_nxt, iter_nxt, prod;
  logic [XLEN-1:0]     quo, rem, calc_res;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0] ext_a, ext_b;
  logic [DW-1:0]        fast_p;
`endif

  always_comb begin
    signed_a = funct3 inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    signed_b = funct3 inside {OP_MULH, OP_DIV, OP_REM};
    neg_a    = signed_a & rs1_data[XLEN-1];
    neg_b    = signed_b & rs2_data[XLEN-1];
    mag_a    = neg_a ? -rs1_data : rs1_data;
    mag_b    = neg_b ? -rs2_data : rs2_data;
    is_div   = funct3[2];

    // Remainder and MULHSU follow the dividend/rs1 sign only.
    case (funct3)
      OP_MULH, OP_DIV:   op_neg = neg_a ^ neg_b;
      OP_MULHSU, OP_REM: op_neg = neg_a;
      default:           op_neg = 1'b0;
    endcase

`ifdef MULDIV_FAST_MUL_EN
    ext_a  = {signed_a & rs1_data[XLEN-1], rs1_data};
    ext_b  = {signed_b & rs2_data[XLEN-1], rs2_data};
    fast_p = DW'(ext_a) * DW'(ext_b);
`endif

    special_hit = 1'b0;
    special_res = '0;
    if (is_div && (rs2_data == '0)) begin
      special_hit = 1'b1;
      special_res = funct3[1] ? rs1_data : '1;
    end else if (is_div && !funct3[0] && (rs1_data == INT_MIN) && (rs2_data == '1)) begin
      special_hit = 1'b1;
      special_res = funct3[1] ? '0 : INT_MIN;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!is_div) begin
      special_hit = 1'b1;
      special_res = (funct3 == OP_MUL) ? fast_p[XLEN-1:0] : fast_p[DW-1:XLEN];
    end
`endif

    // acc_q holds {hi, lo}: product high half / multiplier, or partial remainder / quotient.
    mul_sum   = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_nxt   = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[DW-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (!div_diff[XLEN]) div_nxt = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else                 div_nxt = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    iter_nxt = op_q[2] ? div_nxt : mul_nxt;

    prod = neg_q ? -iter_nxt : iter_nxt;
    quo  = neg_q ? -iter_nxt[XLEN-1:0] : iter_nxt[XLEN-1:0];
    rem  = neg_q ? -iter_nxt[DW-1:XLEN] : iter_nxt[DW-1:XLEN];
    case (op_q)
      OP_MUL:                     calc_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod[DW-1:XLEN];
      OP_DIV, OP_DIVU:            calc_res = quo;
      default:                    calc_res = rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    b_d       = b_q;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;

    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            op_d  = funct3;
            rd_d  = rd;
            neg_d = op_neg;
            cnt_d = '0;
            acc_d = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            b_d   = is_div ? mag_b : mag_a;
            if (special_hit) begin
              wb_reg_d  = rd;
              wb_data_d = special_res;
              state_d   = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_d = iter_nxt;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            wb_reg_d  = rd_q;
            wb_data_d = calc_res;
            state_d   = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      b_q       <= '0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign wb_enable = (state_q == S_DONE) && (rd_q != '0);
  assign wb_reg    = wb_reg_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd = '0;
  logic        flush = 1'b0;
  logic        busy, wb_enable;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd), .flush(flush),
    .busy(busy), .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  // Issues one op and observes it until busy drops; optional junk stimulus while busy.
  task automatic exec_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input bit junk, input bit now,
                         output int wb_at, output int wb_cnt, output int busy_cnt,
                         output logic [31:0] d, output logic [4:0] rg);
    wb_at = -1; wb_cnt = 0; busy_cnt = 0; d = '0; rg = '0;
    if (!now) @(negedge clk);
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b; rd = r;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (junk) begin
        start = 1'($urandom); funct3 = 3'($urandom);
        rs1_data = $urandom; rs2_data = $urandom; rd = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (wb_enable) begin
        wb_cnt++;
        if (wb_at < 0) begin wb_at = k; d = wb_data; rg = wb_reg; end
      end
      if (!busy) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int at, cnt, bc, seen;
    logic [31:0] d;
    logic [4:0] rg;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++;
    if ({busy, wb_enable, wb_reg, wb_data} !== '0) begin
      bad++;
      $display("FAIL reset_init: busy=%b wb_enable=%b wb_reg=%0d wb_data=%h required all zero",
               busy, wb_enable, wb_reg, wb_data);
    end
    exec_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b0, 1'b0, at, cnt, bc, d, rg);
    total++;
    if (d !== 32'hFFFF_FFEB) begin
      bad++; $display("FAIL reset_pre_mul: got %h required %h", d, 32'hFFFF_FFEB);
    end
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3; rd = 5'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++;
    if ({busy, wb_enable, wb_reg, wb_data} !== '0) begin
      bad++;
      $display("FAIL reset_mid_div: busy=%b wb_enable=%b wb_reg=%0d wb_data=%h required all zero",
               busy, wb_enable, wb_reg, wb_data);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || wb_enable) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL reset_no_wb: busy/wb cycles=%0d required 0", seen);
    end
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, b, exp;
    logic [4:0]  r;
  } vec_t;

  task automatic test_directed();
    vec_t v [14];
    int at, cnt, bc, lat;
    logic [31:0] d;
    logic [4:0] rg;
    v[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 5'd5};
    v[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd6};
    v[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7};
    v[3]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5'd8};
    v[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 5'd10};
    v[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 5'd11};
    v[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        5'd12};
    v[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         5'd13};
    v[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 5'd14};
    v[9]  = '{3'd7, 32'd5,         32'd0,         32'd5,         5'd15};
    v[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd16};
    v[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         5'd17};
    v[12] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 5'd18};
    v[13] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 5'd31};
    for (int i = 0; i < 14; i++) begin
      exec_op(v[i].f, v[i].a, v[i].b, v[i].r, 1'b0, 1'b0, at, cnt, bc, d, rg);
      lat = exp_lat(v[i].f, v[i].a, v[i].b);
      total++;
      if (d !== v[i].exp || rg !== v[i].r) begin
        bad++;
        $display("FAIL directed_%0d data/reg: got %h/%0d required %h/%0d", i, d, rg, v[i].exp, v[i].r);
      end
      total++;
      if (at != lat || cnt != 1 || bc != lat) begin
        bad++;
        $display("FAIL directed_%0d timing: wb_at=%0d wb_cnt=%0d busy=%0d required %0d/1/%0d",
                 i, at, cnt, bc, lat, lat);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] corners [5];
    logic [2:0] f;
    logic [31:0] a, b, d, e;
    logic [4:0] r, rg;
    int at, cnt, bc, lat;
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom);
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 300); b = $urandom_range(0, 20); end
        2: begin a = corners[$urandom_range(0, 4)]; b = corners[$urandom_range(0, 4)]; end
        default: begin a = $urandom; b = 32'($urandom_range(0, 15)) - 32'd7; end
      endcase
      r = 5'($urandom_range(1, 31));
      exec_op(f, a, b, r, 1'b0, 1'b0, at, cnt, bc, d, rg);
      e = model(f, a, b);
      lat = exp_lat(f, a, b);
      total++;
      if (d !== e || rg !== r || at != lat || cnt != 1 || bc != lat) begin
        bad++;
        $display("FAIL random_%0d f=%0d a=%h b=%h: data=%h reg=%0d at=%0d cnt=%0d busy=%0d required %h/%0d/%0d/1/%0d",
                 i, f, a, b, d, rg, at, cnt, bc, e, r, lat, lat);
      end
    end
  endtask

  task automatic test_start_during_busy();
    int at, cnt, bc;
    logic [31:0] d;
    logic [4:0] rg;
    exec_op(3'd5, 32'd1000, 32'd7, 5'd3, 1'b1, 1'b0, at, cnt, bc, d, rg);
    total++;
    if (d !== 32'd142 || rg !== 5'd3 || at != 33 || cnt != 1) begin
      bad++;
      $display("FAIL busy_ignore_divu: data=%h reg=%0d at=%0d cnt=%0d required %h/3/33/1", d, rg, at, cnt, 32'd142);
    end
    exec_op(3'd1, 32'hFFFF_FFF0, 32'd3, 5'd4, 1'b1, 1'b0, at, cnt, bc, d, rg);
    total++;
    if (d !== 32'hFFFF_FFFF || rg !== 5'd4 || cnt != 1) begin
      bad++;
      $display("FAIL busy_ignore_mulh: data=%h reg=%0d cnt=%0d required ffffffff/4/1", d, rg, cnt);
    end
  endtask

  task automatic test_flush();
    int seen, at, cnt, bc;
    logic [31:0] d;
    logic [4:0] rg;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; rs1_data = 32'd999; rs2_data = 32'd4; rd = 5'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++;
    if (busy !== 1'b0 || wb_enable !== 1'b0) begin
      bad++; $display("FAIL flush_calc: busy=%b wb_enable=%b required 0/0", busy, wb_enable);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (wb_enable || busy) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL flush_no_wb: busy/wb cycles=%0d required 0", seen);
    end
    start = 1'b1; flush = 1'b1; funct3 = 3'd5; rs1_data = 32'd9; rs2_data = 32'd2; rd = 5'd1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL flush_with_start: busy=%b required 0", busy);
    end
    exec_op(3'd7, 32'd999, 32'd4, 5'd21, 1'b0, 1'b0, at, cnt, bc, d, rg);
    total++;
    if (d !== 32'd3 || rg !== 5'd21 || at != 33) begin
      bad++; $display("FAIL flush_recover: data=%h reg=%0d at=%0d required 3/21/33", d, rg, at);
    end
  endtask

  task automatic test_rd_zero();
    int at, cnt, bc;
    logic [31:0] d;
    logic [4:0] rg;
    exec_op(3'd4, 32'd1000, 32'd7, 5'd0, 1'b0, 1'b0, at, cnt, bc, d, rg);
    total++;
    if (bc != 33 || cnt != 0) begin
      bad++; $display("FAIL rd_zero: busy=%0d wb_cnt=%0d required 33/0", bc, cnt);
    end
  endtask

  task automatic test_back_to_back();
    int at, cnt, bc;
    logic [31:0] d;
    logic [4:0] rg;
    exec_op(3'd5, 32'd77, 32'd5, 5'd2, 1'b0, 1'b0, at, cnt, bc, d, rg);
    total++;
    if (d !== 32'd15 || at != 33) begin
      bad++; $display("FAIL b2b_first: data=%h at=%0d required f/33", d, at);
    end
    exec_op(3'd7, 32'd77, 32'd5, 5'd3, 1'b0, 1'b1, at, cnt, bc, d, rg);
    total++;
    if (d !== 32'd2 || rg !== 5'd3 || at != 33 || bc != 33) begin
      bad++; $display("FAIL b2b_second: data=%h reg=%0d at=%0d busy=%0d required 2/3/33/33", d, rg, at, bc);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_during_busy();
    test_flush();
    test_rd_zero();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
